mmio_port_controller: RTL and testbench
=======================================

# mmio_port_controller

Memory-mapped I/O controller that sits directly downstream of the MIPS processor's ALU/data-memory stage, next to the data memory. It decodes the ALU-computed address, and on a hit it owns the access in place of the data memory. The top level uses `IOSelect` to gate the data-memory write enable and to choose the load data. The block holds the board output port, synchronizes the 8-bit board input port with change detection, and provides a 32-bit auto-reload timer with a sticky expiry flag.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: base of the 32-byte I/O window; must be 32-byte aligned.
- `clk`  input  1: processor clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high.
- `Address`  input  32: byte address from the ALU result.
- `WriteData`  input  32: store data (register-file read data 2).
- `MemWrite`  input  1: store strobe from the control unit.
- `MemRead`  input  1: load strobe from the control unit.
- `PortIn`  input  8: asynchronous board inputs.
- `IOSelect`  output  1: combinational; 1 when `Address[31:5] == BASE_ADDR[31:5]`.
- `ReadData`  output  32: combinational register read data; 0 when `IOSelect=0` or `MemRead=0`.
- `PortOut`  output  32: PORT_OUT register contents; reset 0.

## Operation
- Register map (byte offset `Address[4:0]`; `Address[1:0]` ignored):
  - 0x00 PORT_OUT: read/write.
  - 0x04 PORT_IN: read-only; `{24'b0, sync2}`.
  - 0x08 STATUS: bit0 CHANGED, bit1 EXPIRED, other bits read 0; writing 1 to a bit clears it.
  - 0x0C TIMER_LOAD: read/write.
  - 0x10 TIMER_COUNT: read-only.
  - 0x14–0x1C: read 0, writes ignored.
- Write: `IOSelect & MemWrite` at the clock edge. Read: combinational.
- Input path: two-flop synchronizer `sync1 <= PortIn`, `sync2 <= sync1`.
  - CHANGED sets on any edge where `sync1 != sync2`.
  - CHANGED stays set until cleared by software.
- Timer states:
  - IDLE: count holds 0.
  - RUN, when count > 1: count decrements by 1 each cycle.
  - RUN, when count == 1: count reloads TIMER_LOAD and EXPIRED sets.
- Timer writes:
  - Write TIMER_LOAD = N, N ≠ 0: load register = N, count = N, state goes to RUN. This applies from IDLE or RUN (restart).
  - Write TIMER_LOAD = 0: load register = 0, count = 0, state goes to IDLE.
- Arithmetic: 32-bit unsigned. The count never underflows, because the count==1 reload prevents it.
- Simultaneous events:
  - Status set and write-1-clear of the same bit in one cycle: set wins.
  - TIMER_LOAD write in the same cycle as an expiry: the write wins on count/state, and EXPIRED is not set that cycle.
  - Writes to read-only offsets have no effect.

## Timing
- Reset values: PORT_OUT 0, sync1/sync2 0, CHANGED 0, EXPIRED 0, TIMER_LOAD 0, count 0, state IDLE.
- Reset asserted mid-count: on the next edge all state returns to reset values, and any write that cycle is discarded.
- Write latency: the register value is visible on `ReadData`/`PortOut` one cycle after the store's clock edge.
- Read latency: 0 cycles (combinational), which suits the single-cycle datapath.
- PortIn change before edge k:
  - sync1 updates at k.
  - PORT_IN and CHANGED update at k+1.
- Timer period with load N: EXPIRED sets exactly N cycles after the loading edge, then every N cycles after that.
  - N = 1 expires every cycle.

## Structure
- Shared package holds:
  - register offsets OFF_PORT_OUT/OFF_PORT_IN/OFF_STATUS/OFF_TIMER_LOAD/OFF_TIMER_COUNT;
  - status bit indices STATUS_CHANGED = 0, STATUS_EXPIRED = 1;
  - default MMIO base 32'hFFFF_0000;
  - timer state encoding TIMER_IDLE / TIMER_RUN.
- One sub-module, `io_reload_timer`:
  - inputs: clk, reset, load strobe, load value;
  - outputs: count, one-cycle expire pulse.
- The top level holds address decode, PORT_OUT, the synchronizer, status flags and the read mux.

## Test plan
- Reset, then read all five offsets → all 0; `PortOut = 0`; `IOSelect = 0` at `Address = 0x1001_0000`.
- Store 0x0000_00A5 to 0xFFFF_0000 → `PortOut = 0xA5` after the edge; load from the same address returns 0xA5; data-memory write gated, because `IOSelect = 1`.
- Drive `PortIn = 0x3C` before edge k → PORT_IN = 0x3C and STATUS = 0x1 after edge k+1; write STATUS = 0x1 → STATUS = 0. Repeat with the clear coinciding with a new change → STATUS stays 0x1.
- Write TIMER_LOAD = 4 → TIMER_COUNT reads 4, 3, 2, 1, 4; EXPIRED set on cycle 4 and cycle 8; write STATUS = 0x2 clears it; write TIMER_LOAD = 0 → count 0 and no further expiry.
- TIMER_LOAD = 3 with the reload write landing on the expiry cycle → count = 3 and EXPIRED not set. Then assert reset mid-count → count 0, IDLE, flags 0 on the next edge.
- Store to offset 0x04/0x10/0x18 → no register change; loads from 0x14–0x1C return 0.

Source files
------------

// File: rtl/mmio_port_controller_pkg.sv
// Shared constants and types for the MMIO port controller: register map,
// status bit positions, default window base and timer state encoding.
package mmio_port_controller_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned PORT_IN_W = 8;
    localparam int unsigned OFF_W     = 5;

    localparam logic [DATA_W-1:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

    localparam logic [OFF_W-1:0] OFF_PORT_OUT    = 5'h00;
    localparam logic [OFF_W-1:0] OFF_PORT_IN     = 5'h04;
    localparam logic [OFF_W-1:0] OFF_STATUS      = 5'h08;
    localparam logic [OFF_W-1:0] OFF_TIMER_LOAD  = 5'h0C;
    localparam logic [OFF_W-1:0] OFF_TIMER_COUNT = 5'h10;

    // Word-aligned offsets: the byte-lane bits of the address are dropped
    localparam logic [OFF_W-1:0] OFF_WORD_MASK = 5'h1C;

    localparam int unsigned STATUS_CHANGED = 0;
    localparam int unsigned STATUS_EXPIRED = 1;
    localparam int unsigned STATUS_W       = 2;

    typedef enum logic {
        TIMER_IDLE = 1'b0,
        TIMER_RUN  = 1'b1
    } timerState_e;

endpackage

// File: rtl/mmio_port_controller_if.sv
// Processor-side load/store bus plus board port pins of the MMIO controller.
interface mmio_port_controller_if;
    import mmio_port_controller_pkg::*;

    logic [DATA_W-1:0]    Address;
    logic [DATA_W-1:0]    WriteData;
    logic                 MemWrite;
    logic                 MemRead;
    logic [PORT_IN_W-1:0] PortIn;
    logic                 IOSelect;
    logic [DATA_W-1:0]    ReadData;
    logic [DATA_W-1:0]    PortOut;

    modport master (
        output Address, WriteData, MemWrite, MemRead, PortIn,
        input  IOSelect, ReadData, PortOut
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead, PortIn,
        output IOSelect, ReadData, PortOut
    );
endinterface

// File: rtl/io_reload_timer.sv
// 32-bit auto-reload down counter; expirePulse_c is high in the cycle whose
// clock edge reloads the count, so the owner can latch the event on that edge.
module io_reload_timer
    import mmio_port_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              loadStrobe,
    input  logic [DATA_W-1:0] loadValue,
    output logic [DATA_W-1:0] count,
    output logic              expirePulse_c
);

    timerState_e       state, stateNext;
    logic [DATA_W-1:0] countNext;
    logic [DATA_W-1:0] reloadValue, reloadNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= TIMER_IDLE;
            count       <= '0;
            reloadValue <= '0;
        end else begin
            state       <= stateNext;
            count       <= countNext;
            reloadValue <= reloadNext;
        end
    end

    // A software load overrides both counting and a coincident expiry
    always_comb begin
        stateNext     = state;
        countNext     = count;
        reloadNext    = reloadValue;
        expirePulse_c = 1'b0;
        if (loadStrobe) begin
            reloadNext = loadValue;
            countNext  = loadValue;
            stateNext  = (loadValue != '0) ? TIMER_RUN : TIMER_IDLE;
        end else begin
            case (state)
                TIMER_IDLE: begin
                    countNext = '0;
                end
                TIMER_RUN: begin
                    if (count > DATA_W'(1)) begin
                        countNext = count - DATA_W'(1);
                    end else if (count == DATA_W'(1)) begin
                        countNext     = reloadValue;
                        expirePulse_c = 1'b1;
                    end else begin
                        stateNext = TIMER_IDLE;
                    end
                end
                default: stateNext = TIMER_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mmio_port_controller.sv
// MMIO window decoder with output port, synchronized input port with change
// detection, sticky status flags and an auto-reload timer.
module mmio_port_controller
    import mmio_port_controller_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input logic                 clk,
    input logic                 reset,
    mmio_port_controller_if.slave bus
);

    logic [OFF_W-1:0]     regOffset;
    logic                 wrEn;
    logic                 timerLoadStrobe;
    logic                 expirePulse_c;
    logic [DATA_W-1:0]    timerCount;
    logic [DATA_W-1:0]    portOutReg;
    logic [DATA_W-1:0]    timerLoadReg;
    logic [PORT_IN_W-1:0] sync1, sync2;
    logic [STATUS_W-1:0]  statusFlags, statusSet, statusClr;

    assign bus.IOSelect    = (bus.Address[DATA_W-1:OFF_W] == BASE_ADDR[DATA_W-1:OFF_W]);
    assign regOffset       = bus.Address[OFF_W-1:0] & OFF_WORD_MASK;
    assign wrEn            = bus.IOSelect & bus.MemWrite;
    assign timerLoadStrobe = wrEn && (regOffset == OFF_TIMER_LOAD);
    assign bus.PortOut     = portOutReg;

    // Set events take priority over a write-1-to-clear in the same cycle
    always_comb begin
        statusSet                 = '0;
        statusSet[STATUS_CHANGED] = (sync1 != sync2);
        statusSet[STATUS_EXPIRED] = expirePulse_c;
        statusClr                 = '0;
        if (wrEn && (regOffset == OFF_STATUS)) begin
            statusClr = bus.WriteData[STATUS_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            portOutReg   <= '0;
            timerLoadReg <= '0;
            sync1        <= '0;
            sync2        <= '0;
            statusFlags  <= '0;
        end else begin
            sync1       <= bus.PortIn;
            sync2       <= sync1;
            statusFlags <= statusSet | (statusFlags & ~statusClr);
            if (wrEn && (regOffset == OFF_PORT_OUT)) begin
                portOutReg <= bus.WriteData;
            end
            if (timerLoadStrobe) begin
                timerLoadReg <= bus.WriteData;
            end
        end
    end

    io_reload_timer uTimer (
        .clk           (clk),
        .reset         (reset),
        .loadStrobe    (timerLoadStrobe),
        .loadValue     (bus.WriteData),
        .count         (timerCount),
        .expirePulse_c (expirePulse_c)
    );

    always_comb begin
        bus.ReadData = '0;
        if (bus.IOSelect && bus.MemRead) begin
            case (regOffset)
                OFF_PORT_OUT:    bus.ReadData = portOutReg;
                OFF_PORT_IN:     bus.ReadData = {{(DATA_W-PORT_IN_W){1'b0}}, sync2};
                OFF_STATUS:      bus.ReadData = {{(DATA_W-STATUS_W){1'b0}}, statusFlags};
                OFF_TIMER_LOAD:  bus.ReadData = timerLoadReg;
                OFF_TIMER_COUNT: bus.ReadData = timerCount;
                default:         bus.ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_controller.sv
// Bench for mmio_port_controller: directed register-map scenarios followed by
// random bus traffic, all compared against a cycle-level behavioural model.
module tb_mmio_port_controller;
    import mmio_port_controller_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] portIn;

    always #5 clk = ~clk;

    mmio_port_controller_if bus();

    mmio_port_controller #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int testsRun = 0;
    int testsFailed = 0;

    // Reference state: timer tracked as (period, cycles elapsed since load)
    logic [31:0] mPortOut, mN;
    logic [7:0]  mSync1, mSync2;
    logic        mChanged, mExpired, mRun;
    int unsigned mElapsed;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] expCount();
        if (!mRun) return 32'h0;
        return mN - 32'(mElapsed % mN);
    endfunction

    function automatic logic [31:0] expRead(input logic [31:0] a, input logic rd);
        logic [4:0] off;
        off = a[4:0] & 5'h1C;
        if (a[31:5] != BASE[31:5] || !rd) return 32'h0;
        case (off)
            5'h00:   return mPortOut;
            5'h04:   return {24'h0, mSync2};
            5'h08:   return {30'h0, mExpired, mChanged};
            5'h0C:   return mN;
            5'h10:   return expCount();
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        mPortOut = '0; mN = '0; mSync1 = '0; mSync2 = '0;
        mChanged = 1'b0; mExpired = 1'b0; mRun = 1'b0; mElapsed = 0;
    endtask

    task automatic modelEdge(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                             input logic we, input logic [7:0] pin);
        logic wr, chg, exp;
        logic [4:0] off;
        if (rst) begin
            modelReset();
            return;
        end
        wr  = (a[31:5] == BASE[31:5]) && we;
        off = a[4:0] & 5'h1C;
        chg = (mSync1 != mSync2);
        exp = 1'b0;
        if (mRun) begin
            mElapsed++;
            if (mElapsed % mN == 0) exp = 1'b1;
        end
        if (wr && off == 5'h0C) begin
            mN = wd; mElapsed = 0; mRun = (wd != 0); exp = 1'b0;
        end
        if (wr && off == 5'h00) mPortOut = wd;
        mChanged = chg | (mChanged & !(wr && off == 5'h08 && wd[0]));
        mExpired = exp | (mExpired & !(wr && off == 5'h08 && wd[1]));
        mSync2 = mSync1;
        mSync1 = pin;
    endtask

    // One clock: apply inputs, check combinational outputs mid-cycle, advance model
    task automatic cyc(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic re);
        reset         = rst;
        bus.Address   = a;
        bus.WriteData = wd;
        bus.MemWrite  = we;
        bus.MemRead   = re;
        bus.PortIn    = portIn;
        @(negedge clk);
        checkVal("IOSelect", 32'(bus.IOSelect), 32'(a[31:5] == BASE[31:5]));
        checkVal("ReadData", bus.ReadData, expRead(a, re));
        checkVal("PortOut", bus.PortOut, mPortOut);
        @(posedge clk);
        modelEdge(rst, a, wd, we, portIn);
        #1;
    endtask

    task automatic peekK(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.Address  = a;
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        #1;
        checkVal(tag, bus.ReadData, exp);
    endtask

    task automatic peekM(input string tag, input logic [31:0] a);
        peekK(tag, a, expRead(a, 1'b1));
    endtask

    initial begin
        portIn = 8'h00;
        reset = 1'b1; bus.Address = '0; bus.WriteData = '0;
        bus.MemWrite = 1'b0; bus.MemRead = 1'b0; bus.PortIn = '0;
        modelReset();
        @(posedge clk); #1;
        cyc(1'b1, BASE, 32'h0, 1'b0, 1'b0);

        // Reset values and decode
        for (int i = 0; i < 5; i++) peekK("rstRead", BASE + 32'(4 * i), 32'h0);
        checkVal("rstPortOut", bus.PortOut, 32'h0);
        bus.Address = 32'h1001_0000; #1;
        checkVal("ioSelOff", 32'(bus.IOSelect), 32'h0);
        cyc(1'b0, 32'h1001_0000, 32'h0, 1'b0, 1'b1);

        // Output port store and readback
        cyc(1'b0, BASE, 32'h0000_00A5, 1'b1, 1'b0);
        checkVal("portOutA5", bus.PortOut, 32'h0000_00A5);
        peekK("readPortOut", BASE, 32'h0000_00A5);
        checkVal("ioSelOn", 32'(bus.IOSelect), 32'h1);

        // Input synchronizer and CHANGED flag
        portIn = 8'h3C;
        cyc(1'b0, BASE + 32'h8, 32'h0, 1'b0, 1'b1);
        peekK("portInK", BASE + 32'h4, 32'h0);
        cyc(1'b0, BASE + 32'h4, 32'h0, 1'b0, 1'b1);
        peekK("portInK1", BASE + 32'h4, 32'h0000_003C);
        peekK("changedSet", BASE + 32'h8, 32'h1);
        cyc(1'b0, BASE + 32'h8, 32'h1, 1'b1, 1'b0);
        peekK("changedClr", BASE + 32'h8, 32'h0);
        portIn = 8'h5A;
        cyc(1'b0, BASE, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, BASE + 32'h8, 32'h1, 1'b1, 1'b0);
        peekK("setWinsClr", BASE + 32'h8, 32'h1);
        cyc(1'b0, BASE + 32'h8, 32'h1, 1'b1, 1'b0);
        peekK("changedClr2", BASE + 32'h8, 32'h0);

        // Timer period 4
        cyc(1'b0, BASE + 32'hC, 32'd4, 1'b1, 1'b0);
        peekK("cnt4", BASE + 32'h10, 32'd4);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
            peekK("cntDown", BASE + 32'h10, 32'(4 - i));
            peekK("noExpYet", BASE + 32'h8, 32'h0);
        end
        cyc(1'b0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
        peekK("cntReload", BASE + 32'h10, 32'd4);
        peekK("expired4", BASE + 32'h8, 32'h2);
        cyc(1'b0, BASE + 32'h8, 32'h2, 1'b1, 1'b0);
        peekK("expClr", BASE + 32'h8, 32'h0);
        cyc(1'b0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
        peekK("noExp7", BASE + 32'h8, 32'h0);
        cyc(1'b0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
        peekK("expired8", BASE + 32'h8, 32'h2);
        cyc(1'b0, BASE + 32'h8, 32'h2, 1'b1, 1'b0);
        cyc(1'b0, BASE + 32'hC, 32'h0, 1'b1, 1'b0);
        peekK("cntStop", BASE + 32'h10, 32'h0);
        for (int i = 0; i < 6; i++) cyc(1'b0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
        peekK("noExpIdle", BASE + 32'h8, 32'h0);

        // Reload write coinciding with expiry, then reset mid-count
        cyc(1'b0, BASE + 32'hC, 32'd3, 1'b1, 1'b0);
        cyc(1'b0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
        peekK("cntAt1", BASE + 32'h10, 32'd1);
        cyc(1'b0, BASE + 32'hC, 32'd3, 1'b1, 1'b0);
        peekK("writeWinsCnt", BASE + 32'h10, 32'd3);
        peekK("writeWinsExp", BASE + 32'h8, 32'h0);
        cyc(1'b0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, BASE, 32'h77, 1'b1, 1'b0);
        peekK("rstCnt", BASE + 32'h10, 32'h0);
        peekK("rstLoad", BASE + 32'hC, 32'h0);
        peekK("rstStatus", BASE + 32'h8, 32'h0);
        peekK("rstPortIn", BASE + 32'h4, 32'h0);
        checkVal("rstDropsWrite", bus.PortOut, 32'h0);

        // Read-only and reserved offsets
        cyc(1'b0, BASE + 32'h4, 32'hFFFF_FFFF, 1'b1, 1'b0);
        cyc(1'b0, BASE + 32'h10, 32'h0000_0009, 1'b1, 1'b0);
        cyc(1'b0, BASE + 32'h18, 32'h1234_5678, 1'b1, 1'b0);
        peekM("roPortIn", BASE + 32'h4);
        peekK("roCount", BASE + 32'h10, 32'h0);
        peekK("roLoad", BASE + 32'hC, 32'h0);
        checkVal("roPortOut", bus.PortOut, 32'h0);
        for (int i = 0; i < 3; i++) peekK("rsvdRead", BASE + 32'h14 + 32'(4 * i), 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, wd;
            logic rst, we, re;
            if ($urandom_range(0, 7) == 0) portIn = 8'($urandom);
            a   = ($urandom_range(0, 9) == 0) ? $urandom : (BASE | 32'($urandom_range(0, 31)));
            we  = ($urandom_range(0, 2) == 0);
            re  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            wd  = ((a[4:0] & 5'h1C) == 5'h0C) ? 32'($urandom_range(0, 6)) : $urandom;
            cyc(rst, a, wd, we, re);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
